// File: rtl/mimc_pkg.sv
// Shared constants and types for the MiMC Miyaguchi-Preneel sponge.
// Holds the BN254 scalar modulus, the default field width and the FSM states.
package mimc_pkg;

  localparam int MIMC_N_BITS = 254;

  // BN254 scalar field modulus r
  // (21888242871839275222246405745257275088548364400416034343698204186575808495617).
  localparam logic [MIMC_N_BITS-1:0] BN254_P =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    UPDATE,
    OUT
  } state_t;

endpackage

// File: rtl/mimc_mod_add3.sv
// Combinational three-operand modular addition: y = (a + b + c) mod p.
// Operands are assumed already reduced (< p), so the raw sum is below 3p and
// two conditional subtractions are always enough.
module mimc_mod_add3 #(
  parameter int                N_BITS = mimc_pkg::MIMC_N_BITS,
  parameter logic [N_BITS-1:0] P      = N_BITS'(mimc_pkg::BN254_P)
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [N_BITS-1:0] c,
  output logic [N_BITS-1:0] y
);

  localparam logic [N_BITS+1:0] P_EXT = {2'b00, P};

  logic [N_BITS+1:0] sum_raw;
  logic [N_BITS+1:0] sum_once;

  // Widen by two bits so a + b + c (< 3p) never overflows, then reduce twice.
  always_comb begin
    sum_raw  = {2'b00, a} + {2'b00, b} + {2'b00, c};
    sum_once = (sum_raw >= P_EXT) ? (sum_raw - P_EXT) : sum_raw;
    y        = N_BITS'((sum_once >= P_EXT) ? (sum_once - P_EXT) : sum_once);
  end

endmodule

// File: rtl/mimc_hash_sponge.sv
// Miyaguchi-Preneel hash around an external MiMC cipher.
//   h0 = 0; per block m: c = E_h(m); h = (h + m + c) mod P; digest = final h.
// The cipher is a separate block driven through cipher_en/in/key and
// answering with cipher_out/cipher_done.
// Optional build macro MIMC_HASH_RANGE_CHECK_EN adds output msg_err and drops
// any offered block with msg_data >= P instead of absorbing it.
module mimc_hash_sponge
  import mimc_pkg::*;
#(
  parameter int                N_BITS = MIMC_N_BITS,
  parameter logic [N_BITS-1:0] P      = N_BITS'(BN254_P)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [N_BITS-1:0] msg_data,
  input  logic              msg_last,
`ifdef MIMC_HASH_RANGE_CHECK_EN
  output logic              msg_err,
`endif
  output logic              cipher_en,
  output logic [N_BITS-1:0] cipher_in,
  output logic [N_BITS-1:0] cipher_key,
  input  logic [N_BITS-1:0] cipher_out,
  input  logic              cipher_done,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [N_BITS-1:0] digest
);

  state_t            state_q;
  state_t            state_d;
  logic [N_BITS-1:0] m_q;
  logic              last_q;
  logic [N_BITS-1:0] c_q;
  logic [N_BITS-1:0] h_q;
  logic [N_BITS-1:0] h_next;
  logic              accept;
  logic              drop;
  logic              range_bad;

`ifdef MIMC_HASH_RANGE_CHECK_EN
  logic msg_err_q;

  // Out-of-field blocks are rejected at the handshake instead of absorbed.
  assign range_bad = (msg_data >= P);
  assign msg_err   = msg_err_q;
`else
  assign range_bad = 1'b0;
`endif

  // Next-state logic; cipher_done only matters while waiting on the cipher.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (msg_valid) begin
          if (range_bad) begin
            drop = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = START;
          end
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (cipher_done) state_d = UPDATE;
      UPDATE:  state_d = last_q ? OUT : IDLE;
      OUT:     if (digest_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset forces IDLE asynchronously, abandoning any block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  // Chaining value update: h + m + c reduced modulo P.
  mimc_mod_add3 #(
    .N_BITS (N_BITS),
    .P      (P)
  ) u_mod_add3 (
    .a (h_q),
    .b (m_q),
    .c (c_q),
    .y (h_next)
  );

  // Datapath registers: latched block, cipher result and chaining value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every datapath register is reset, not just the control state,
      // because cipher_in/cipher_key are visible outputs that must read 0.
      m_q    <= '0;
      last_q <= 1'b0;
      c_q    <= '0;
      h_q    <= '0;
    end else begin
      if (accept) begin
        m_q    <= msg_data;
        last_q <= msg_last;
      end
      if ((state_q == WAIT) && cipher_done) begin
        c_q <= cipher_out;
      end
      if (state_q == UPDATE) begin
        h_q <= h_next;
      end else if ((state_q == OUT) && digest_ready) begin
        h_q <= '0;
      end
    end
  end

`ifdef MIMC_HASH_RANGE_CHECK_EN
  // One-cycle error pulse for each dropped out-of-range block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_err_q <= 1'b0;
    end else begin
      msg_err_q <= drop;
    end
  end
`else
  // Without the range check nothing is ever dropped.
  logic drop_unused;
  assign drop_unused = drop;
`endif

  // Outputs decode directly from state; in/key come straight from registers
  // that only change outside START/WAIT, so they stay stable for the cipher.
  assign msg_ready    = (state_q == IDLE);
  assign cipher_en    = (state_q == START);
  assign cipher_in    = m_q;
  assign cipher_key   = h_q;
  assign digest_valid = (state_q == OUT);
  assign digest       = (state_q == OUT) ? h_q : '0;

endmodule

// File: doc/mimc_hash_sponge.md
MIMC_HASH_SPONGE -- requirements
Module: mimc_hash_sponge

Interface
REQ-001 SHALL have parameter N_BITS, default 254, which sets the field element width.
REQ-002 SHALL have parameter P, default BN254 scalar modulus 21888242871839275222246405745257275088548364400416034343698204186575808495617, which is the field prime.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port msg_valid, input, 1 bit: a message block is offered.
REQ-006 SHALL have port msg_ready, output, 1 bit: the block accepts a message.
REQ-007 SHALL have port msg_data, input, N_BITS: the message block, a field element.
REQ-008 SHALL have port msg_last, input, 1 bit: this block is the final block of the message.
REQ-009 SHALL have port cipher_en, output, 1 bit: one-cycle start pulse to the downstream MiMC cipher.
REQ-010 SHALL have port cipher_in, output, N_BITS: the cipher plaintext.
REQ-011 SHALL have port cipher_key, output, N_BITS: the cipher key.
REQ-012 SHALL have port cipher_out, input, N_BITS: the cipher ciphertext.
REQ-013 SHALL have port cipher_done, input, 1 bit: the cipher result is valid.
REQ-014 SHALL have port digest_valid, output, 1 bit: a hash result is available.
REQ-015 SHALL have port digest_ready, input, 1 bit: the consumer accepts the digest.
REQ-016 SHALL have port digest, output, N_BITS: the hash result.

Function
REQ-017 SHALL implement Miyaguchi-Preneel over the cipher: h0=0; per block m: c=E_h(m); h=(h+m+c) mod P; digest = h after the msg_last block.
REQ-018 SHALL use FSM states IDLE, START, WAIT, UPDATE, OUT.
REQ-019 IDLE: msg_ready=1; on msg_valid&&msg_ready, SHALL latch m and last, then go to START.
REQ-020 START: SHALL assert cipher_en for exactly one cycle, with cipher_in=m and cipher_key=h held stable from START until leaving WAIT; then go to WAIT.
REQ-021 WAIT: SHALL capture cipher_out on the first cycle cipher_done=1, then go to UPDATE; no timeout.
REQ-022 SHALL ignore cipher_done in any state other than WAIT.
REQ-023 UPDATE: SHALL compute s=h+m+c with N_BITS+2 bits, reduce with at most two conditional subtractions of P, and write the result to h; then go to OUT if last, else IDLE.
REQ-024 OUT: SHALL hold digest_valid=1 and digest=h until digest_ready; on handshake SHALL reset h to 0 and go to IDLE in the same edge.
REQ-025 Inputs msg_data < P SHALL be the caller's responsibility unless REQ-032 applies.
REQ-026 SHALL have latency per block of 3 cycles plus cipher latency, from message accept to return to IDLE/OUT.
REQ-027 Back-to-back messages SHALL incur no extra bubble beyond the OUT handshake cycle.

Reset
REQ-028 On rst low, SHALL go to IDLE asynchronously with h=0 and all latched registers 0.
REQ-029 Reset values SHALL be msg_ready=1 once rst releases, and cipher_en=0, cipher_in=0, cipher_key=0, digest_valid=0, digest=0.
REQ-030 Reset mid-WAIT SHALL abandon the block; a late cipher_done afterwards SHALL be ignored per REQ-022.

Configuration
REQ-031 SHALL support macro MIMC_HASH_RANGE_CHECK_EN.
REQ-032 With MIMC_HASH_RANGE_CHECK_EN defined: SHALL add output msg_err (1 bit); a handshaked msg_data >= P SHALL pulse msg_err for one cycle, and the block SHALL be dropped without absorption, state unchanged, remaining in IDLE.
REQ-033 Without MIMC_HASH_RANGE_CHECK_EN: SHALL have no msg_err port and no comparator; every block is absorbed.

Structure
REQ-034 Package mimc_pkg SHALL hold the BN254 modulus constant, the default N_BITS, and the FSM state enum.
REQ-035 SHALL use one sub-module, mimc_mod_add3, for the combinational three-operand modular addition (REQ-023).
REQ-036 The cipher SHALL be external, not instantiated inside this block.

Verification (bench uses stub cipher: done 4 cycles after en, out programmable)
REQ-037 Single block: msg=1, last=1, stub out=5 -> one cipher_en pulse with key=0, in=1; digest=6.
REQ-038 Wrap: msg=P-1, stub out=P-1, last=1 -> digest=P-2.
REQ-039 Two blocks: msg 1 then 2 (last), stub out 5 then 7 -> second cipher_key=6; digest=15.
REQ-040 Backpressure: digest_ready low 10 cycles -> digest stable and msg_ready=0 throughout; after handshake, next message starts with key=0.
REQ-041 Reset asserted in WAIT, spurious cipher_done after release -> FSM in IDLE, h=0, no digest_valid.
REQ-042 With MIMC_HASH_RANGE_CHECK_EN: msg=P -> msg_err one-cycle pulse, no cipher_en; a following msg=1, last=1, stub out=5 -> digest=6.
